ram_arb: RTL and testbench

- Parametrised single-array word memory shared by an instruction-fetch port and a data load/store port.
- Each port uses a valid/ready request handshake with a 1-cycle registered response.
- A fair arbiter gives the data port priority but bounds fetch starvation. Byte write strobes and out-of-range detection are added.
- Sits between the CPU core's fetch/execute stages and the backing storage, replacing the fixed 32-bit, 64K-word, mode-select memory.

---
 rtl/ram_arb.sv | 123 ++++++++++++
 tb/tb_ram_arb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_arb.sv
// ram_arb: word memory shared by a fetch port and a data port.
// Data port wins arbitration, but a pending fetch is forced through after
// STARVE_LIM consecutive losses. Each accepted request is acked one cycle
// later; out-of-range addresses are acked with err=1, rdata=0, no write.
// Ports: clk, rst_n, enable; d_* data request/response; f_* fetch
// request/response.
module ram_arb #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int STARVE_LIM = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic                  d_we,
  input  logic [31:0]           d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic                  d_ack,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_err,
  input  logic                  f_valid,
  output logic                  f_ready,
  input  logic [31:0]           f_addr,
  output logic                  f_ack,
  output logic [DATA_W-1:0]     f_rdata,
  output logic                  f_err
);

  localparam int NB = DATA_W / 8;
  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [3:0]        starve_q, starve_d;
  logic              d_ack_q, d_ack_d;
  logic              f_ack_q, f_ack_d;
  logic              d_err_q, d_err_d;
  logic              f_err_q, f_err_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;

  logic              force_f;
  logic              d_oor, f_oor;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] rd_word;
  logic              wr_en;

  assign force_f = (starve_q == LIM);
  assign d_ready = enable & d_valid & ~(force_f & f_valid);
  assign f_ready = enable & f_valid & (~d_valid | force_f);

  assign d_oor = |d_addr[31:ADDR_W];
  assign f_oor = |f_addr[31:ADDR_W];

  // At most one port is granted per cycle, so one address mux suffices.
  assign idx = d_ready ? d_addr[ADDR_W-1:0]
                       : f_addr[ADDR_W-1:0];
  assign rd_word = mem[idx];
  assign wr_en   = d_ready & d_we & ~d_oor;

  always_comb begin
    starve_d  = starve_q;
    d_ack_d   = d_ready;
    f_ack_d   = f_ready;
    d_err_d   = d_ready & d_oor;
    f_err_d   = f_ready & f_oor;
    d_rdata_d = d_rdata_q;
    f_rdata_d = f_rdata_q;

    if (enable) begin
      if (!f_valid || f_ready)
        starve_d = '0;
      else if (starve_q != LIM)
        starve_d = starve_q + 4'd1;
    end

    if (d_ready && !d_we)
      d_rdata_d = d_oor ? '0 : rd_word;
    if (f_ready)
      f_rdata_d = f_oor ? '0 : rd_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q  <= '0;
      d_ack_q   <= 1'b0;
      f_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      f_err_q   <= 1'b0;
      d_rdata_q <= '0;
      f_rdata_q <= '0;
    end else begin
      starve_q  <= starve_d;
      d_ack_q   <= d_ack_d;
      f_ack_q   <= f_ack_d;
      d_err_q   <= d_err_d;
      f_err_q   <= f_err_d;
      d_rdata_q <= d_rdata_d;
      f_rdata_q <= f_rdata_d;
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (d_wstrb[i])
          mem[idx][i*8 +: 8] <= d_wdata[i*8 +: 8];
      end
    end
  end

  assign d_ack   = d_ack_q;
  assign f_ack   = f_ack_q;
  assign d_err   = d_err_q;
  assign f_err   = f_err_q;
  assign d_rdata = d_rdata_q;
  assign f_rdata = f_rdata_q;

endmodule

// File: tb/tb_ram_arb.sv
// tb_ram_arb: directed and random checks of ram_arb against a
// behavioural model (word map, loss count, expected responses).
module tb_ram_arb;

  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          d_valid, d_ready, d_we;
  logic [31:0]   d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_wstrb;
  logic          d_ack, d_err;
  logic [DW-1:0] d_rdata;
  logic          f_valid, f_ready;
  logic [31:0]   f_addr;
  logic          f_ack, f_err;
  logic [DW-1:0] f_rdata;

  always #5 clk = ~clk;

  ram_arb #(
    .DATA_W(DW), .ADDR_W(AW), .STARVE_LIM(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(en),
    .d_valid(d_valid), .d_ready(d_ready), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .f_valid(f_valid), .f_ready(f_ready), .f_addr(f_addr),
    .f_ack(f_ack), .f_rdata(f_rdata), .f_err(f_err)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] mem_m [logic [31:0]];
  int          losses;
  logic        e_dack, e_fack, e_derr, e_ferr;
  logic [31:0] e_drd, e_frd;
  logic [31:0] word0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic oor(logic [31:0] a);
    return a >= 32'(1 << AW);
  endfunction

  function automatic logic [31:0] rd_m(logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : 32'h0;
  endfunction

  task automatic setd(logic v, logic we, logic [31:0] a,
                      logic [31:0] wd, logic [3:0] s);
    d_valid = v; d_we = we; d_addr = a; d_wdata = wd; d_wstrb = s;
  endtask

  task automatic setf(logic v, logic [31:0] a);
    f_valid = v; f_addr = a;
  endtask

  // One clock of traffic: predict grants from the arbitration rule
  // (forced fetch wins, otherwise data wins), then check the responses.
  task automatic step();
    logic ff, df;
    logic [31:0] w;
    #1;
    ff = en && f_valid && (!d_valid || losses == LIM);
    df = en && d_valid && !ff;
    chk("d_ready", 32'(d_ready), 32'(df));
    chk("f_ready", 32'(f_ready), 32'(ff));
    if (en) begin
      if (f_valid && !ff) losses = (losses < LIM) ? losses + 1 : LIM;
      else losses = 0;
    end
    e_dack = df;
    e_fack = ff;
    e_derr = df && oor(d_addr);
    e_ferr = ff && oor(f_addr);
    if (df && !d_we) e_drd = oor(d_addr) ? 32'h0 : rd_m(d_addr);
    if (ff) e_frd = oor(f_addr) ? 32'h0 : rd_m(f_addr);
    if (df && d_we && !oor(d_addr)) begin
      w = rd_m(d_addr);
      for (int b = 0; b < 4; b++)
        if (d_wstrb[b]) w[b*8 +: 8] = d_wdata[b*8 +: 8];
      mem_m[d_addr] = w;
    end
    @(posedge clk);
    #1;
    chk("d_ack", 32'(d_ack), 32'(e_dack));
    chk("f_ack", 32'(f_ack), 32'(e_fack));
    if (e_dack) chk("d_err", 32'(d_err), 32'(e_derr));
    if (e_fack) chk("f_err", 32'(f_err), 32'(e_ferr));
    chk("d_rdata", d_rdata, e_drd);
    chk("f_rdata", f_rdata, e_frd);
  endtask

  initial begin
    rst_n = 1'b1;
    en = 1'b0;
    setd(0, 0, 0, 0, 0);
    setf(0, 0);
    losses = 0;
    e_dack = 0; e_fack = 0; e_derr = 0; e_ferr = 0;
    e_drd = 0; e_frd = 0;
    #3 rst_n = 1'b0;
    #5;
    chk("rst_d_ack", 32'(d_ack), 0);
    chk("rst_f_ack", 32'(f_ack), 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_errs", 32'({d_err, f_err}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      setd(1, 1, i, $urandom, 4'hF);
      step();
    end
    word0 = rd_m(0);

    // full-word write then read
    setd(1, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    step();
    setd(1, 0, 32'h10, 0, 0);
    step();
    chk("t1_rdata", d_rdata, 32'hDEADBEEF);
    chk("t1_err", 32'(d_err), 0);

    // byte strobes, read back via fetch
    setd(1, 1, 32'h10, 32'h11223344, 4'b0101);
    step();
    setd(0, 0, 0, 0, 0);
    setf(1, 32'h10);
    step();
    chk("t2_frdata", f_rdata, 32'hDE22BE44);

    // starvation pattern, period STARVE_LIM+1
    setd(1, 0, 32'h5, 0, 0);
    setf(1, 32'h3);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("starve_f", 32'(f_ready), 32'((i % 5) == 4));
      chk("starve_d", 32'(d_ready), 32'((i % 5) != 4));
      step();
    end
    setf(0, 0);

    // out-of-range write and read
    setd(1, 1, 32'h0001_0000, 32'h12345678, 4'hF);
    step();
    chk("t4_werr", 32'(d_err), 1);
    setd(1, 0, 32'h0, 0, 0);
    step();
    chk("t4_word0", d_rdata, word0);
    setd(1, 0, 32'h0001_0000, 0, 0);
    step();
    chk("t4_rdata", d_rdata, 0);
    chk("t4_rerr", 32'(d_err), 1);

    // enable low blocks requests
    setd(1, 0, 32'h1, 0, 0);
    step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_noack", 32'(d_ack), 0);
    end
    en = 1'b1;

    // reset after an accepted read drops the ack
    setd(1, 0, 32'h2, 0, 0);
    setf(0, 0);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_d_ack", 32'(d_ack), 0);
    chk("t6_f_ack", 32'(f_ack), 0);
    setd(0, 0, 0, 0, 0);
    e_drd = 0; e_frd = 0; losses = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_noack", 32'({d_ack, f_ack}), 0);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      en = ($urandom % 8) != 0;
      setd($urandom % 2, $urandom % 2,
           ($urandom % 8 == 0) ? (32'h10000 | $urandom)
                               : 32'($urandom % 16),
           $urandom, 4'($urandom % 16));
      setf($urandom % 2,
           ($urandom % 8 == 0) ? (32'h10000 | $urandom)
                               : 32'($urandom % 16));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
